// File: rtl/ir_nec_rx_avalon.sv
// NEC infrared frame receiver with an Avalon-MM register interface.
// The active-low IR line is synchronised, majority-filtered on a 1 us tick,
// and each mark/space is timed to decode 32-bit frames and repeat codes.
module ir_nec_rx_avalon #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TIMEOUT_US  = 12000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        ir_in,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);
    localparam int          DIV = (CLK_FREQ_HZ / 1000000 > 0) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam int          PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [15:0] TO  = 16'(TIMEOUT_US);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        RPT_MARK   = 3'd5,
        CHECK      = 3'd6
    } state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic in_rng(input logic [15:0] d, input logic [15:0] lo, input logic [15:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          sync_1, sync_2;
    logic [2:0]    samp;
    logic          filt, filt_d;
    logic          fall, rise;
    logic [15:0]   dur;
    state_t        state;
    logic [5:0]    bit_idx;
    logic [31:0]   shift;
    logic [31:0]   data_reg;
    logic          hw_valid, hw_rpt, hw_err;
    logic          ctrl_ien, ctrl_chk;
    logic          st_valid, st_rpt, st_err, st_ovr;
    logic          wr, rd;
    logic          unused_bits;

    assign fall        = filt_d & ~filt;
    assign rise        = ~filt_d & filt;
    assign wr          = avs_chipselect & avs_write;
    assign rd          = avs_chipselect & avs_read;
    assign irq         = ctrl_ien & st_valid;
    assign unused_bits = ^avs_writedata[31:4];

    // 1 us tick generator
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt == PW'(DIV - 1)) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
            tick    <= 1'b0;
        end
    end

    // Two-flop synchroniser, 3-sample majority filter on ticks, edge history
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            samp   <= 3'b111;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            sync_1 <= ir_in;
            sync_2 <= sync_1;
            if (tick) begin
                samp <= {samp[1:0], sync_2};
            end
            filt   <= maj3(samp);
            filt_d <= filt;
        end
    end

    // Phase duration in us, restarted on every filtered edge, saturating at the timeout
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            dur <= 16'd0;
        end else if (fall || rise) begin
            dur <= 16'd0;
        end else if (tick && (dur < TO)) begin
            dur <= dur + 16'd1;
        end
    end

    // Frame decoder FSM; flag requests are one-cycle registered pulses
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state    <= IDLE;
            bit_idx  <= 6'd0;
            shift    <= 32'd0;
            data_reg <= 32'd0;
            hw_valid <= 1'b0;
            hw_rpt   <= 1'b0;
            hw_err   <= 1'b0;
        end else begin
            hw_valid <= 1'b0;
            hw_rpt   <= 1'b0;
            hw_err   <= 1'b0;
            if ((state != IDLE) && (state != CHECK) && !fall && !rise && (dur == TO)) begin
                hw_err <= 1'b1;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall) state <= LEAD_MARK;
                    end
                    LEAD_MARK: begin
                        if (rise) begin
                            // A short leader mark is treated as noise, not an error
                            state <= in_rng(dur, 16'd8000, 16'd10000) ? LEAD_SPACE : IDLE;
                        end
                    end
                    LEAD_SPACE: begin
                        if (fall) begin
                            if (in_rng(dur, 16'd4000, 16'd5000)) begin
                                state   <= BIT_MARK;
                                bit_idx <= 6'd0;
                                shift   <= 32'd0;
                            end else if (in_rng(dur, 16'd1800, 16'd2700)) begin
                                state <= RPT_MARK;
                            end else begin
                                hw_err <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    BIT_MARK: begin
                        if (rise) begin
                            if (!in_rng(dur, 16'd400, 16'd700)) begin
                                hw_err <= 1'b1;
                                state  <= IDLE;
                            end else if (bit_idx == 6'd32) begin
                                state <= CHECK;
                            end else begin
                                state <= BIT_SPACE;
                            end
                        end
                    end
                    BIT_SPACE: begin
                        if (fall) begin
                            if (in_rng(dur, 16'd400, 16'd700) || in_rng(dur, 16'd1400, 16'd1900)) begin
                                shift[bit_idx[4:0]] <= (dur >= 16'd1400);
                                bit_idx             <= bit_idx + 6'd1;
                                state               <= BIT_MARK;
                            end else begin
                                hw_err <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    RPT_MARK: begin
                        if (rise) begin
                            if (in_rng(dur, 16'd400, 16'd700)) begin
                                hw_rpt <= 1'b1;
                            end else begin
                                hw_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    CHECK: begin
                        if (ctrl_chk && ((shift[15:8] != ~shift[7:0]) || (shift[31:24] != ~shift[23:16]))) begin
                            hw_err <= 1'b1;
                        end else begin
                            data_reg <= shift;
                            hw_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // CTRL/STATUS registers: hardware set beats W1C and read-clear in the same cycle
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ctrl_ien <= 1'b0;
            ctrl_chk <= 1'b0;
            st_valid <= 1'b0;
            st_rpt   <= 1'b0;
            st_err   <= 1'b0;
            st_ovr   <= 1'b0;
        end else begin
            if (wr && (avs_address == 2'd2)) begin
                ctrl_ien <= avs_writedata[0];
                ctrl_chk <= avs_writedata[1];
            end
            st_valid <= hw_valid | (st_valid & ~((wr && (avs_address == 2'd1) && avs_writedata[0]) ||
                                                  (rd && (avs_address == 2'd0))));
            st_rpt   <= hw_rpt | (st_rpt & ~(wr && (avs_address == 2'd1) && avs_writedata[1]));
            st_err   <= hw_err | (st_err & ~(wr && (avs_address == 2'd1) && avs_writedata[2]));
            st_ovr   <= (hw_valid & st_valid) | (st_ovr & ~(wr && (avs_address == 2'd1) && avs_writedata[3]));
        end
    end

    // Registered read data, latency 1
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= 32'd0;
        end else if (rd) begin
            case (avs_address)
                2'd0:    avs_readdata <= data_reg;
                2'd1:    avs_readdata <= {28'd0, st_ovr, st_err, st_rpt, st_valid};
                2'd2:    avs_readdata <= {30'd0, ctrl_chk, ctrl_ien};
                default: avs_readdata <= 32'd0;
            endcase
        end else begin
            avs_readdata <= 32'd0;
        end
    end
endmodule

// File: tb/tb_ir_nec_rx_avalon.sv
// Directed bench for the NEC receiver; 1 MHz clock so one cycle is one microsecond.
module tb_ir_nec_rx_avalon;
    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        ir_in;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    ir_nec_rx_avalon #(.CLK_FREQ_HZ(1000000), .TIMEOUT_US(12000)) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .ir_in          (ir_in),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .irq            (irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mark(input int us);
        ir_in = 1'b0;
        repeat (us) @(negedge clk_clk);
    endtask

    task automatic space(input int us);
        ir_in = 1'b1;
        repeat (us) @(negedge clk_clk);
    endtask

    // Leader plus nbits data bits (LSB first); stop mark and idle gap only for full frames.
    // glitch_bit >= 0 puts a 1 us low pulse inside that bit's space.
    task automatic send_frame(input logic [31:0] d, input int nbits, input int glitch_bit);
        int sp;
        mark(9000);
        space(4500);
        for (int i = 0; i < nbits; i++) begin
            mark(560);
            sp = d[i] ? 1690 : 560;
            if (i == glitch_bit) begin
                space(800);
                mark(1);
                space(sp - 801);
            end else begin
                space(sp);
            end
        end
        if (nbits == 32) begin
            mark(560);
            space(2000);
        end
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_clk);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = a;
        @(negedge clk_clk);
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        d = avs_readdata;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = a;
        avs_writedata  = d;
        @(negedge clk_clk);
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
    endtask

    initial begin
        reset_reset    = 1'b1;
        ir_in          = 1'b1;
        avs_address    = 2'd0;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = 32'd0;
        repeat (5) @(negedge clk_clk);
        check("reset_readdata", avs_readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset_reset = 1'b0;
        space(20);
        bus_rd(2'd0, rv); check("reset_data", rv, 32'h0);
        bus_rd(2'd1, rv); check("reset_status", rv, 32'h0);
        bus_rd(2'd2, rv); check("reset_ctrl", rv, 32'h0);

        // Valid frame with checking enabled, interrupt still masked
        bus_wr(2'd2, 32'h2);
        send_frame(32'hBA45FF00, 32, -1);
        bus_rd(2'd1, rv); check("frame1_status", rv, 32'h1);
        check("frame1_irq_masked", {31'd0, irq}, 32'd0);
        bus_wr(2'd2, 32'h3);
        check("frame1_irq_on", {31'd0, irq}, 32'd1);
        bus_rd(2'd2, rv); check("ctrl_rw", rv, 32'h3);
        bus_wr(2'd0, 32'h12345678);
        bus_wr(2'd3, 32'hFFFFFFFF);
        bus_rd(2'd3, rv); check("reserved_zero", rv, 32'h0);

        // Repeat code
        mark(9000); space(2250); mark(560); space(1000);
        bus_rd(2'd1, rv); check("repeat_status", rv, 32'h3);
        bus_wr(2'd1, 32'h2);
        bus_rd(2'd1, rv); check("rpt_w1c", rv, 32'h1);
        bus_rd(2'd0, rv); check("frame1_data", rv, 32'hBA45FF00);
        check("irq_after_read", {31'd0, irq}, 32'd0);
        bus_rd(2'd1, rv); check("valid_read_clear", rv, 32'h0);

        // Corrupted ~cmd with check on: error, DATA kept
        send_frame(32'hBB45FF00, 32, -1);
        bus_rd(2'd1, rv); check("corrupt_status", rv, 32'h4);
        bus_rd(2'd0, rv); check("corrupt_data_kept", rv, 32'hBA45FF00);
        bus_wr(2'd1, 32'h4);
        bus_rd(2'd1, rv); check("err_w1c", rv, 32'h0);

        // Same frame with check off is accepted
        bus_wr(2'd2, 32'h1);
        send_frame(32'hBB45FF00, 32, -1);
        bus_rd(2'd1, rv); check("nochk_status", rv, 32'h1);
        check("nochk_irq", {31'd0, irq}, 32'd1);

        // Line stuck low after the leader space: timeout at 12000 us
        mark(9000); space(4500);
        mark(11900);
        bus_rd(2'd1, rv); check("stuck_before_timeout", rv, 32'h1);
        mark(300);
        bus_rd(2'd1, rv); check("stuck_timeout_err", rv, 32'h5);
        mark(2796);
        space(3000);

        // Good frame with a 1 us glitch in a '1' space; second valid frame gives overrun
        send_frame(32'hBA45FF00, 32, 8);
        bus_rd(2'd1, rv); check("glitch_ovr_status", rv, 32'hD);
        check("irq_before_read", {31'd0, irq}, 32'd1);
        bus_rd(2'd0, rv); check("glitch_data", rv, 32'hBA45FF00);
        check("irq_drop", {31'd0, irq}, 32'd0);
        bus_rd(2'd1, rv); check("after_read_status", rv, 32'hC);

        // Reset in the middle of a frame, then a full frame
        send_frame(32'hF708FB04, 17, -1);
        reset_reset = 1'b1;
        repeat (3) @(negedge clk_clk);
        check("midreset_readdata", avs_readdata, 32'd0);
        reset_reset = 1'b0;
        bus_rd(2'd0, rv); check("midreset_data", rv, 32'h0);
        bus_rd(2'd1, rv); check("midreset_status", rv, 32'h0);
        bus_rd(2'd2, rv); check("midreset_ctrl", rv, 32'h0);
        space(1000);
        send_frame(32'hF708FB04, 32, -1);
        bus_rd(2'd1, rv); check("post_reset_status", rv, 32'h1);
        check("post_reset_irq", {31'd0, irq}, 32'd0);
        bus_rd(2'd0, rv); check("post_reset_data", rv, 32'hF708FB04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_nec_rx_avalon.md
Name: ir_nec_rx_avalon

Overview:
- NEC infrared frame decoder. Samples the demodulated, active-low IR receiver line that arrives at the kernel's IR conduit input.
- Measures mark/space durations with a 1 us timebase and assembles 32-bit frames. Recognises repeat codes.
- Exposes results to the Nios II through an Avalon-MM slave (data, status, control) and a level interrupt.
- Sits between the IR conduit pin and the system interconnect. The CPU consumes its key codes to drive the LCD.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; sets the 1 us prescaler (CLK_FREQ_HZ/1000000 − 1).
- TIMEOUT_US, 12000, maximum duration of any single phase before the frame is aborted.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- ir_in  in  1  raw IR receiver output; idle high, mark = low; asynchronous to clk_clk.
- avs_address  in  2  register select.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; registered, fixed read latency 1.
- irq  out  1  level interrupt, = CTRL.ien & STATUS.valid.

Behaviour:
- Reset: all registers and FSM cleared.
  - avs_readdata = 0, irq = 0, DATA = 0, STATUS = 0, CTRL = 0.
  - FSM = IDLE; synchroniser flops = 1.
- Input conditioning:
  - 2-FF synchroniser, then a 3-sample majority filter on 1 us ticks.
  - Edges are detected on the filtered signal.
- Duration counter:
  - 16-bit us counter, cleared on every filtered edge; saturates at TIMEOUT_US.
  - Reaching TIMEOUT_US in any state other than IDLE: STATUS.err = 1, FSM → IDLE.
- FSM (durations in us, bounds inclusive):
  - IDLE: falling edge → LEAD_MARK.
  - LEAD_MARK: on rising edge:
    - count 8000–10000 → LEAD_SPACE.
    - else → IDLE. No error flagged (treated as noise).
  - LEAD_SPACE: on falling edge:
    - 4000–5000 → BIT_MARK, bit index = 0, shift register cleared.
    - 1800–2700 → RPT_MARK.
    - else → err = 1, IDLE.
  - BIT_MARK: on rising edge:
    - 400–700 → BIT_SPACE when index < 32.
    - 400–700 → CHECK when index = 32 (this is the stop mark).
    - else → err, IDLE.
  - BIT_SPACE: on falling edge:
    - 400–700 shifts in 0; 1400–1900 shifts in 1.
    - Bits are LSB first: bit n goes to shift[n]. Index increments, then → BIT_MARK.
    - Other duration → err, IDLE.
  - RPT_MARK: on rising edge:
    - 400–700 → STATUS.rpt = 1, IDLE.
    - Repeat codes never alter DATA or valid.
    - else → err, IDLE.
  - CHECK (one cycle):
    - If CTRL.chk = 1 and (shift[15:8] ≠ ~shift[7:0] or shift[31:24] ≠ ~shift[23:16]): err = 1, DATA unchanged.
    - Otherwise: DATA ← shift. If valid was already 1, ovr = 1. Then valid = 1.
    - → IDLE.
- Register map (word addresses):
  - 0 DATA (RO): [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
  - 1 STATUS (R/W1C): bit0 valid, bit1 rpt, bit2 err, bit3 ovr. Other bits read 0.
  - 2 CTRL (RW): bit0 ien, bit1 chk. Other bits read 0.
  - 3 reserved: reads 0, writes ignored.
- Reading DATA (chipselect & read, address 0) clears valid on the same edge that registers readdata. The returned value is the pre-clear DATA.
- Simultaneous hardware set and W1C/read-clear of the same flag in one cycle: set wins.
- Writes to DATA are ignored.
- Reset asserted mid-frame: immediate return to the reset state. A partial frame is discarded with no flags.

Test Plan:
- Valid frame, addr 0x00, cmd 0x45, chk = 1 → DATA = 0xBA45FF00, STATUS = 0x1. irq = 1 only after CTRL = 0x3 is written.
- Repeat burst (9000 mark, 2250 space, 560 mark) after the frame → STATUS = 0x3, DATA unchanged. Writing STATUS = 0x2 → STATUS = 0x1.
- Corrupted ~cmd (cmd 0x45, ~cmd 0xBB) with chk = 1 → err = 1, DATA keeps its old value. Same frame with chk = 0 → DATA = 0xBB45FF00, valid = 1.
- Two valid frames with no intervening DATA read → ovr = 1, DATA = second frame. A DATA read then returns the second frame and clears valid; irq drops the cycle after.
- Line stuck low for 15 ms after the leader space → err = 1 at 12000 us, FSM IDLE. A following good frame decodes correctly.
- 1 us glitch inside a bit space ignored, and the frame decodes. Reset pulsed at bit 17 → all registers 0, the next full frame decodes.
